// File: rtl/iq_result_packer_pkg.sv
// Shared types and constants for the FCx5 I/Q result packer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: halfword width, lane count, buffer depth, default header magic, FSM state enum.
package iq_result_packer_pkg;

   localparam int HW_W       = 16;
   localparam int FCX5_LANES = 5;
   localparam int BUF_DEPTH  = 8;

   localparam logic [HW_W-1:0] HDR_MAGIC_DEF = 16'hA5A5;

   typedef logic [HW_W-1:0] hw_t;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      FLUSH
   } state_t;

endpackage

// File: rtl/iq_result_packer_gearbox.sv
// 4:5 halfword gearbox: 8-entry buffer, push 0/2/4 halfwords, pop 5 per beat, zero-padded flush.
// Latency: a full beat is registered onto the lanes on the edge after fill reaches 5.
// Backpressure: none; the sink must take every beat, and the caller never overfills.
// Ports: clk, rst (async active-low), push_n/push_hw (append, index 0 oldest), flush (pad out a
//        partial beat), fill (current occupancy), lanes/lanes_vld (registered output beat).
module fcx5_gearbox
   import iq_result_packer_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             push_n,
   input  hw_t  [3:0]             push_hw,
   input  logic                   flush,
   output logic [3:0]             fill,
   output hw_t  [FCX5_LANES-1:0]  lanes,
   output logic                   lanes_vld
);

   hw_t  [BUF_DEPTH-1:0]  buf_q;
   hw_t  [BUF_DEPTH-1:0]  buf_d;
   hw_t  [FCX5_LANES-1:0] pad_lanes;
   logic [3:0]            fill_q;
   logic [3:0]            fill_d;
   logic [3:0]            rem;
   logic [3:0]            idx;
   logic                  emit;
   logic                  pad;

   always_comb begin
      emit      = (fill_q >= 4'd5);
      // A pad beat only happens when a flush is requested and no full beat is available.
      pad       = flush && !emit && (fill_q != 4'd0);
      pad_lanes = '0;
      for (int k = 0; k < FCX5_LANES; k++) begin
         if (4'(k) < fill_q) pad_lanes[k] = buf_q[k];
      end

      // Step 1: remove what is emitted this edge; oldest entry always sits at index 0.
      if (emit) begin
         rem   = fill_q - 4'd5;
         buf_d = buf_q >> (FCX5_LANES * HW_W);
      end else if (pad) begin
         rem   = '0;
         buf_d = '0;
      end else begin
         rem   = fill_q;
         buf_d = buf_q;
      end

      // Step 2: append behind what remains. rem <= 4 here, so rem + 3 never exceeds 7.
      idx = '0;
      for (int j = 0; j < 4; j++) begin
         if (3'(j) < push_n) begin
            idx             = rem + 4'(j);
            buf_d[idx[2:0]] = push_hw[j];
         end
      end
      fill_d = rem + {1'b0, push_n};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q     <= '0;
         fill_q    <= '0;
         lanes     <= '0;
         lanes_vld <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         fill_q    <= fill_d;
         lanes_vld <= emit || pad;
         if (emit) begin
            lanes <= buf_q[FCX5_LANES-1:0];
         end else if (pad) begin
            lanes <= pad_lanes;
         end
      end
   end

   assign fill = fill_q;

endmodule

// File: rtl/iq_result_packer.sv
// Packs I/Q results into framed 5-lane x 16-bit FCx5 beats: {magic, count} header, 4 halfwords/point, zero pad.
// Latency: an accepted point reaches the lanes within two edges while points keep streaming.
// Backpressure: iq_ready is high throughout PAYLOAD; the output side has none (out_valid only).
// Ports: clk, rst (async active-low), start/num_data_pts (frame request), iq_valid/iq_ready/i_val/q_val
//        (point input), out_data_0..4/out_valid (beat output), busy, frame_done (last-beat pulse).
module iq_result_packer
   import iq_result_packer_pkg::*;
#(
   parameter logic [HW_W-1:0] HDR_MAGIC = HDR_MAGIC_DEF,
   parameter int              CNT_W     = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_data_pts,
   input  logic              iq_valid,
   output logic              iq_ready,
   input  logic [31:0]       i_val,
   input  logic [31:0]       q_val,
   output logic [15:0]       out_data_0,
   output logic [15:0]       out_data_1,
   output logic [15:0]       out_data_2,
   output logic [15:0]       out_data_3,
   output logic [15:0]       out_data_4,
   output logic              out_valid,
   output logic              busy,
   output logic              frame_done
);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic                  accept;
   logic [2:0]            push_n;
   hw_t  [3:0]            push_hw;
   logic                  flush;
   logic [3:0]            fill;
   hw_t  [FCX5_LANES-1:0] lanes;

   assign busy     = (state != IDLE);
   assign iq_ready = (state == PAYLOAD);
   assign accept   = iq_valid && iq_ready;

   always_comb begin
      push_n  = '0;
      push_hw = '0;
      flush   = 1'b0;
      case (state)
         HEADER: begin
            push_n     = 3'd2;
            push_hw[0] = HDR_MAGIC;
            push_hw[1] = HW_W'(cnt);
         end
         PAYLOAD: begin
            if (accept) begin
               push_n     = 3'd4;
               push_hw[0] = i_val[15:0];
               push_hw[1] = i_val[31:16];
               push_hw[2] = q_val[15:0];
               push_hw[3] = q_val[31:16];
            end
         end
         FLUSH: flush = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt   <= num_data_pts;
                  state <= HEADER;
               end
            end
            HEADER: state <= (cnt == '0) ? FLUSH : PAYLOAD;
            PAYLOAD: begin
               if (accept) begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= FLUSH;
               end
            end
            FLUSH: begin
               // fill <= 5 means this edge drains the buffer (full beat, pad beat, or nothing left).
               if (fill <= 4'd5) begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fcx5_gearbox u_gearbox (
      .clk       (clk),
      .rst       (rst),
      .push_n    (push_n),
      .push_hw   (push_hw),
      .flush     (flush),
      .fill      (fill),
      .lanes     (lanes),
      .lanes_vld (out_valid)
   );

   assign out_data_0 = lanes[0];
   assign out_data_1 = lanes[1];
   assign out_data_2 = lanes[2];
   assign out_data_3 = lanes[3];
   assign out_data_4 = lanes[4];

endmodule

// File: tb/tb_iq_result_packer.sv
// Self-checking bench for iq_result_packer: framed beats compared against a halfword-list model.
// Driver issues frames and queues the expected beats; a negedge monitor pops and compares each beat.
module tb_iq_result_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_data_pts;
   logic        iq_valid;
   logic        iq_ready;
   logic [31:0] i_val;
   logic [31:0] q_val;
   logic [15:0] out_data_0, out_data_1, out_data_2, out_data_3, out_data_4;
   logic        out_valid;
   logic        busy;
   logic        frame_done;

   typedef struct {
      logic [4:0][15:0] d;
      bit               done;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] pts_i[$];
   logic [31:0] pts_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   iq_result_packer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_data_pts (num_data_pts),
      .iq_valid     (iq_valid),
      .iq_ready     (iq_ready),
      .i_val        (i_val),
      .q_val        (q_val),
      .out_data_0   (out_data_0),
      .out_data_1   (out_data_1),
      .out_data_2   (out_data_2),
      .out_data_3   (out_data_3),
      .out_data_4   (out_data_4),
      .out_valid    (out_valid),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: frame = header, then 4 halfwords per point, padded to a multiple of 5.
   task automatic queue_frame(input int n);
      logic [15:0] hw[$];
      beat_t       b;
      hw.push_back(16'hA5A5);
      hw.push_back(16'(n));
      for (int p = 0; p < n; p++) begin
         hw.push_back(pts_i[p][15:0]);
         hw.push_back(pts_i[p][31:16]);
         hw.push_back(pts_q[p][15:0]);
         hw.push_back(pts_q[p][31:16]);
      end
      while (hw.size() % 5 != 0) hw.push_back(16'h0000);
      for (int s = 0; s < hw.size(); s += 5) begin
         for (int k = 0; k < 5; k++) b.d[k] = hw[s+k];
         b.done = (s + 5 == hw.size());
         exp_q.push_back(b);
      end
   endtask

   task automatic gen_pts(input int n);
      pts_i.delete();
      pts_q.delete();
      for (int p = 0; p < n; p++) begin
         pts_i.push_back($urandom);
         pts_q.push_back($urandom);
      end
   endtask

   // Monitor: every valid beat must match the next expected one.
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {out_data_4, out_data_3, out_data_2, out_data_1, out_data_0}, 80'h0);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_data", {out_data_4, out_data_3, out_data_2, out_data_1, out_data_0}, b.d);
               chk("frame_done_flag", frame_done, b.done);
            end
         end else begin
            chk("frame_done_without_beat", frame_done, 1'b0);
         end
      end
   end

   // Called just after a negedge. mode: 0 valid held high, 1 valid every other cycle, 2 random.
   // Returns at the negedge where frame_done is seen (or after a mid-frame reset).
   task automatic run_frame(input int n, input int mode, input int stray_at, input int rst_after,
                            output int rdy_cnt, output int rdy_span);
      int idx = 0, cyc = 0, first = -1, last = -1;
      bit done = 0;
      rdy_cnt  = 0;
      rdy_span = 0;
      queue_frame(n);
      chk("busy_before_start", busy, 1'b0);
      start        = 1'b1;
      num_data_pts = 16'(n);
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            chk("busy_after_start", busy, 1'b1);
         end
         if (stray_at > 0) begin
            if (cyc == stray_at) begin
               start        = 1'b1;
               num_data_pts = 16'd7;
            end else if (cyc == stray_at + 1) begin
               start = 1'b0;
            end
         end
         if (frame_done) begin
            done = 1;
         end else if (rst_after >= 0 && idx == rst_after) begin
            iq_valid = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("rst_out_data", {out_data_4, out_data_3, out_data_2, out_data_1, out_data_0}, 80'h0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_iq_ready", iq_ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_frame_done", frame_done, 1'b0);
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst = 1'b1;
            return;
         end else begin
            if (iq_ready) begin
               rdy_cnt++;
               if (first < 0) first = cyc;
               last = cyc;
            end
            case (mode)
               0:       iq_valid = 1'b1;
               1:       iq_valid = (cyc % 2 == 1);
               default: iq_valid = ($urandom_range(0, 1) == 1);
            endcase
            if (idx < n) begin
               i_val = pts_i[idx];
               q_val = pts_q[idx];
            end else begin
               i_val = $urandom;
               q_val = $urandom;
            end
            if (iq_valid && iq_ready) idx++;
         end
      end
      iq_valid = 1'b0;
      start    = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_timeout: got no frame_done required one (n=%0d)", n);
      end
      if (first >= 0) rdy_span = last - first + 1;
      #1;
      chk("beats_per_frame_left", exp_q.size(), 0);
      chk("busy_at_frame_done", busy, 1'b0);
   endtask

   int rc, rs;

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      num_data_pts = '0;
      iq_valid     = 1'b0;
      i_val        = '0;
      q_val        = '0;
      #3;
      chk("reset_out_data", {out_data_4, out_data_3, out_data_2, out_data_1, out_data_0}, 80'h0);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_iq_ready", iq_ready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_frame_done", frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // N=1 with known values.
      pts_i = {32'h11112222};
      pts_q = {32'h33334444};
      run_frame(1, 0, -1, -1, rc, rs);
      chk("n1_ready_cycles", rc, 1);
      repeat (3) @(negedge clk);
      #1;

      // N=0: header-only beat, iq_ready never asserted despite iq_valid held high.
      gen_pts(0);
      run_frame(0, 0, -1, -1, rc, rs);
      chk("n0_ready_cycles", rc, 0);
      repeat (3) @(negedge clk);
      #1;

      // N=10 streaming: ready for exactly 10 consecutive cycles.
      gen_pts(10);
      run_frame(10, 0, -1, -1, rc, rs);
      chk("n10_ready_cycles", rc, 10);
      chk("n10_ready_span", rs, 10);
      repeat (3) @(negedge clk);
      #1;

      // N=5 with gapped valid and a stray start while busy.
      gen_pts(5);
      run_frame(5, 1, 4, -1, rc, rs);
      repeat (3) @(negedge clk);
      #1;

      // Reset after 3 of 8 points, then a clean N=1 frame.
      gen_pts(8);
      run_frame(8, 0, -1, 3, rc, rs);
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst_out_valid", out_valid, 1'b0);
      gen_pts(1);
      run_frame(1, 0, -1, -1, rc, rs);
      repeat (3) @(negedge clk);
      #1;

      // Back-to-back frames: each start issued right at the frame_done cycle of the previous one.
      gen_pts(3);
      run_frame(3, 2, -1, -1, rc, rs);
      gen_pts(2);
      run_frame(2, 0, -1, -1, rc, rs);
      gen_pts(4);
      run_frame(4, 2, -1, -1, rc, rs);
      repeat (3) @(negedge clk);
      #1;

      // Random frames.
      for (int f = 0; f < 6; f++) begin
         int n;
         n = $urandom_range(0, 12);
         gen_pts(n);
         run_frame(n, 2, -1, -1, rc, rs);
         chk("rand_ready_vs_points", (rc >= n), 1'b1);
         repeat ($urandom_range(1, 3)) @(negedge clk);
         #1;
      end

      repeat (5) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
